// File: rtl/exe_muldiv_unit_pkg.sv
// Shared encodings for the EXE-stage iterative multiply/divide engine.
package exe_muldiv_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SIGN = 2'd2
  } state_e;

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/exe_muldiv_unit_if.sv
// Operand/control bundle between the ID/EXE register, hazard control and the mul/div engine.
interface exe_muldiv_unit_if #(parameter int XLEN = 32) ();
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            cancel;
  logic            hi_we;
  logic            lo_we;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            stall_req;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, cancel, hi_we, lo_we, wdata,
    input  busy, stall_req, done, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, cancel, hi_we, lo_we, wdata,
    output busy, stall_req, done, hi, lo
  );
endinterface

// File: rtl/exe_muldiv_unit_abs.sv
// Conditional two's-complement negate; gives |x| when neg_i is the sign bit of a signed value.
module muldiv_abs #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? (~val_i + {{(W-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/exe_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO; one iteration per clock, XLEN iterations.
//
// state   | meaning
// IDLE    | waiting for start; MTHI/MTLO writes honoured here
// CALC    | one shift-add / restoring-divide step per cycle
// SIGN    | sign fix of magnitude result, write HI/LO
module exe_muldiv_unit
  import exe_muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic               clk,
  input logic               rst,
  exe_muldiv_unit_if.slave  bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic                sign_a_q, sign_a_d;
  logic                sign_b_q, sign_b_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]     hi_q, hi_d;
  logic [XLEN-1:0]     lo_q, lo_d;
  logic                done_q, done_d;

  op_e             op_in;
  logic            rs_neg, rt_neg;
  logic [XLEN-1:0] rs_abs, rt_abs;
  logic            accept;

  assign op_in  = op_e'(bus.op);
  assign rs_neg = op_is_signed(op_in) & bus.rs_val[XLEN-1];
  assign rt_neg = op_is_signed(op_in) & bus.rt_val[XLEN-1];
  assign accept = (state_q == ST_IDLE) && bus.start && !bus.cancel;

  muldiv_abs #(.W(XLEN)) u_abs_rs (.val_i(bus.rs_val), .neg_i(rs_neg), .res_o(rs_abs));
  muldiv_abs #(.W(XLEN)) u_abs_rt (.val_i(bus.rt_val), .neg_i(rt_neg), .res_o(rt_abs));

  // acc holds {upper, lower}: multiply = {partial sum, multiplier}, divide = {remainder, dividend/quotient}
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     rem_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge   = rem_sh >= {1'b0, opnd_q};
    div_rem  = rem_sh[XLEN-1:0] - opnd_q;
    div_next = div_ge ? {div_rem, acc_q[XLEN-2:0], 1'b1}
                      : {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
  end

  // Divide by zero leaves quotient all ones and remainder |rs|; skipping only the quotient
  // negate makes HI come back as the original rs for both DIV and DIVU.
  logic              div_by_zero;
  logic              quot_neg;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;

  assign div_by_zero = (opnd_q == {XLEN{1'b0}});
  assign quot_neg    = (sign_a_q ^ sign_b_q) & ~div_by_zero;

  muldiv_abs #(.W(2*XLEN)) u_fix_prod (
    .val_i(acc_q), .neg_i(sign_a_q ^ sign_b_q), .res_o(prod_fix)
  );
  muldiv_abs #(.W(XLEN)) u_fix_quot (
    .val_i(acc_q[XLEN-1:0]), .neg_i(quot_neg), .res_o(quot_fix)
  );
  muldiv_abs #(.W(XLEN)) u_fix_rem (
    .val_i(acc_q[2*XLEN-1:XLEN]), .neg_i(sign_a_q), .res_o(rem_fix)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d     = op_in;
          sign_a_d = rs_neg;
          sign_b_d = rt_neg;
          cnt_d    = '0;
          state_d  = ST_CALC;
          if (op_is_div(op_in)) begin
            opnd_d = rt_abs;
            acc_d  = {{XLEN{1'b0}}, rs_abs};
          end else begin
            opnd_d = rs_abs;
            acc_d  = {{XLEN{1'b0}}, rt_abs};
          end
        end else begin
          if (bus.hi_we) hi_d = bus.wdata;
          if (bus.lo_we) lo_d = bus.wdata;
        end
      end
      ST_CALC: begin
        acc_d = op_is_div(op_q) ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_SIGN;
      end
      ST_SIGN: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (op_is_div(op_q)) begin
          lo_d = quot_fix;
          hi_d = rem_fix;
        end else begin
          hi_d = prod_fix[2*XLEN-1:XLEN];
          lo_d = prod_fix[XLEN-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.cancel && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MULT;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.stall_req = accept || bus.busy;
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed bench for exe_muldiv_unit: arithmetic results, latency, cancel, ignored writes, async reset.
module tb_exe_muldiv_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exe_muldiv_unit_if #(.XLEN(32)) bus ();

  exe_muldiv_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of cycle cyc0 after the start cycle; returns at the negedge of the done cycle.
  task automatic wait_done(input string tag, input int cyc0, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
    int   cyc;
    logic stall_ok;
    cyc      = cyc0;
    stall_ok = 1'b1;
    while (bus.done !== 1'b1 && cyc < 40) begin
      if (bus.stall_req !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, cyc, 34);
    chk({tag, "_stall_hold"}, stall_ok, 1);
    chk({tag, "_stall_at_done"}, bus.stall_req, 0);
    chk({tag, "_hi"}, bus.hi, exp_hi);
    chk({tag, "_lo"}, bus.lo, exp_lo);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = a;
    bus.rt_val = b;
    #1 chk({tag, "_stall_c0"}, bus.stall_req, 1);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(tag, 1, exp_hi, exp_lo);
  endtask

  logic saw_done;

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.op     = 2'd0;
    bus.rs_val = '0;
    bus.rt_val = '0;
    bus.cancel = 1'b0;
    bus.hi_we  = 1'b0;
    bus.lo_we  = 1'b0;
    bus.wdata  = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_stall", bus.stall_req, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",  2'd0, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div_neg",   2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf",   2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_zero", 2'd3, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF);
    run_op("div_zero",  2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // cancel at cycle 10 of a DIVU
    bus.start  = 1'b1;
    bus.op     = 2'd3;
    bus.rs_val = 32'd1000;
    bus.rt_val = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    saw_done  = 1'b0;
    repeat (9) begin
      if (bus.done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    chk("cancel_busy_before", bus.busy, 1);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    chk("cancel_busy_after", bus.busy, 0);
    chk("cancel_stall_after", bus.stall_req, 0);
    chk("cancel_no_done", {bus.done, saw_done}, 2'b00);
    chk("cancel_hi_kept", bus.hi, 32'hFFFF_FFF9);
    chk("cancel_lo_kept", bus.lo, 32'hFFFF_FFFF);
    run_op("divu_after_cancel", 2'd3, 32'd1000, 32'd7, 32'd6, 32'h0000_008E);

    // start together with cancel in IDLE is not accepted
    bus.start  = 1'b1;
    bus.cancel = 1'b1;
    bus.op     = 2'd1;
    #1 chk("start_cancel_stall", bus.stall_req, 0);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    chk("start_cancel_busy", bus.busy, 0);

    // second start and MTHI/MTLO while busy are ignored
    bus.start  = 1'b1;
    bus.op     = 2'd0;
    bus.rs_val = 32'd5;
    bus.rt_val = 32'd6;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = 2'd3;
    bus.rs_val = 32'd9;
    bus.rt_val = 32'd3;
    bus.hi_we  = 1'b1;
    bus.lo_we  = 1'b1;
    bus.wdata  = 32'h0000_1234;
    @(negedge clk);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    wait_done("mult_ignore", 6, 32'h0000_0000, 32'h0000_001E);

    bus.hi_we = 1'b1;
    bus.wdata = 32'h0000_1234;
    @(negedge clk);
    bus.hi_we = 1'b0;
    chk("mthi_hi", bus.hi, 32'h0000_1234);
    chk("mthi_lo_kept", bus.lo, 32'h0000_001E);
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_ABCD;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    chk("mthilo_hi", bus.hi, 32'h0000_ABCD);
    chk("mthilo_lo", bus.lo, 32'h0000_ABCD);

    // MTLO alongside an accepted start is dropped
    bus.start  = 1'b1;
    bus.op     = 2'd1;
    bus.rs_val = 32'd2;
    bus.rt_val = 32'd3;
    bus.lo_we  = 1'b1;
    bus.wdata  = 32'h0000_5555;
    @(negedge clk);
    bus.start = 1'b0;
    bus.lo_we = 1'b0;
    chk("mtlo_with_start", bus.lo, 32'h0000_ABCD);
    wait_done("multu_small", 1, 32'h0000_0000, 32'h0000_0006);

    // async reset mid-CALC
    bus.hi_we = 1'b1;
    bus.wdata = 32'h0000_0077;
    @(negedge clk);
    bus.hi_we  = 1'b0;
    bus.start  = 1'b1;
    bus.op     = 2'd1;
    bus.rs_val = 32'hFFFF_FFFF;
    bus.rt_val = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_mid_busy_before", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_hi", bus.hi, 0);
    chk("rst_mid_lo", bus.lo, 0);
    chk("rst_mid_flags", {bus.busy, bus.done, bus.stall_req}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_idle", bus.busy, 0);
    run_op("multu_post_rst", 2'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/exe_muldiv_unit.md
Name: exe_muldiv_unit

Overview:
- Execute-stage consumer of the ID/EXE pipeline register's multiply/divide operands.
- Iterative 32-cycle MULT/MULTU/DIV/DIVU engine that owns the HI/LO registers.
- Raises a stall request back to the hazard/stall control so the ID/EXE register holds while it works.
- Sits beside the ALU in EXE. Results are read through hi/lo by MFHI/MFLO.

Parameters:
- XLEN, 32, operand width; iteration count equals XLEN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  EXE-stage mul/div instruction valid this cycle
- op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- rs_val  in  XLEN  operand A (multiplicand/dividend)
- rt_val  in  XLEN  operand B (multiplier/divisor)
- cancel  in  1  pipeline flush; aborts operation
- hi_we  in  1  MTHI write
- lo_we  in  1  MTLO write
- wdata  in  XLEN  MTHI/MTLO data
- busy  out  1  engine not IDLE
- stall_req  out  1  start accepted this cycle OR busy; holds IF/ID/EXE
- done  out  1  one-cycle pulse, HI/LO just updated
- hi  out  XLEN  HI register
- lo  out  XLEN  LO register

Behaviour:
- Reset (async): state=IDLE, hi=0, lo=0, done=0, busy=0, internal counter/accumulators=0.
- States: IDLE, CALC, SIGN.
- IDLE:
  - start && !cancel: latch op, record signs (signed ops only), latch |rs_val| and |rt_val| (raw values for unsigned ops), counter=0, go to CALC.
  - start is sampled only in IDLE; start while busy is ignored.
- CALC, one iteration per cycle:
  - Multiply: shift-add into 2*XLEN product.
  - Divide: restoring step (shift remainder, trial subtract, set quotient bit).
  - After XLEN iterations (counter==XLEN-1), go to SIGN.
- SIGN (single cycle):
  - Multiply: negate the 2*XLEN product if sign_a^sign_b; HI=upper half, LO=lower half.
  - Divide: quotient negated if sign_a^sign_b, remainder negated if sign_a; LO=quotient, HI=remainder.
  - Go to IDLE; done=1 in the following cycle.
- Latency: start sampled at edge 0; CALC at edges 1..XLEN; SIGN writes HI/LO at edge XLEN+1. done and the new HI/LO are visible in cycle XLEN+2 (34 for XLEN=32).
- busy=1 in CALC and SIGN. stall_req is combinational: (state==IDLE && start && !cancel) || busy.
- stall_req deasserts in the same cycle done is high, so the instruction in EXE retires exactly once.
- Divide by zero (no trap): LO=all ones, HI=rs_val (original, unsigned-interpreted). Same for DIV; sign fix is suppressed.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, produced by natural wrap with no special case.
- cancel in any state: next state IDLE, HI/LO unchanged, no done. cancel with start in IDLE: not accepted.
- hi_we/lo_we: honoured only in IDLE with no accepted start; ignored while busy. Both may be set together.
- MTHI/MTLO write and SIGN write cannot coincide, since SIGN is busy.
- Async reset mid-operation: immediate IDLE with reset values; any partial result is discarded.
- All arithmetic is modulo 2^XLEN per half; no exceptions raised.

Decomposition:
- Shared package: op encodings (OP_MULT..OP_DIVU) and state encodings.
- Sub-module muldiv_abs: combinational abs/negate with a signed flag, instantiated for operand conditioning and sign fix.
- Iteration datapath stays in the top module.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> done at cycle 34; HI=0xFFFFFFFE, LO=0x00000001; stall_req high cycles 0..33.
- MULT -7*3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100/0 -> LO=0xFFFFFFFF, HI=0x00000064; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- cancel asserted at cycle 10 of a DIVU -> busy low next cycle, no done, HI/LO keep prior values; new start accepted immediately after.
- start pulsed again at cycle 5 of a running MULT, and hi_we=1 with wdata=0x1234 while busy -> both ignored; hi_we in IDLE later -> HI=0x1234, LO unchanged.
- rst asserted mid-CALC asynchronously -> hi=lo=0, busy=done=stall_req=0 before the next clk edge.
